// File: rtl/opcode_sequencer_if.sv
// Handshake and status bundle between an instruction source and opcode_sequencer.
// The master drives opcodes and control requests; the slave returns decode, timing and status.
interface opcode_sequencer_if #(
  parameter int OPCODE_WIDTH = 3,
  parameter int NUM_STEPS    = 8,
  parameter int SC_WIDTH     = 3
);
  logic [OPCODE_WIDTH-1:0]      opcode;
  logic                         opcode_valid;
  logic                         opcode_ready;
  logic                         sc_clr;
  logic                         halt;
  logic [(1<<OPCODE_WIDTH)-1:0] decoded_signal;
  logic [NUM_STEPS-1:0]         timing_signal;
  logic [SC_WIDTH-1:0]          sc_count;
  logic                         busy;
  logic                         instr_done;
  logic                         halted;

  modport master (
    output opcode, opcode_valid, sc_clr, halt,
    input  opcode_ready, decoded_signal, timing_signal, sc_count, busy, instr_done, halted
  );

  modport slave (
    input  opcode, opcode_valid, sc_clr, halt,
    output opcode_ready, decoded_signal, timing_signal, sc_count, busy, instr_done, halted
  );
endinterface

// File: rtl/opcode_sequencer.sv
// Instruction sequencer: latches a one-hot opcode decode and steps a one-hot timing
// signal T0..T(NUM_STEPS-1) until early clear, terminal count, or a sticky halt.
//
// state     | meaning
// S_IDLE    | waiting for an opcode, ready while halt is low
// S_EXEC    | instruction running, timing steps advancing
// S_HALTED  | stopped; only reset leaves this state
module opcode_sequencer #(
  parameter int OPCODE_WIDTH = 3,
  parameter int NUM_STEPS    = 8,
  parameter int SC_WIDTH     = 3
) (
  input logic             i_clk,
  input logic             i_rst_n,
  opcode_sequencer_if.slave bus
);
  localparam int DEC_W = 1 << OPCODE_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXEC   = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t                r_state;
  logic [DEC_W-1:0]      r_decoded;
  logic [NUM_STEPS-1:0]  r_timing;
  logic [SC_WIDTH-1:0]   r_sc;
  logic                  r_done;

  wire w_ready = (r_state == S_IDLE) && !bus.halt;
  wire w_term  = (r_sc == SC_WIDTH'(NUM_STEPS - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_decoded <= '0;
      r_timing  <= '0;
      r_sc      <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.halt) begin
            r_state   <= S_HALTED;
            r_decoded <= '0;
            r_timing  <= '0;
            r_sc      <= '0;
          end else if (bus.opcode_valid) begin
            r_state   <= S_EXEC;
            r_decoded <= DEC_W'(1) << bus.opcode;
            r_timing  <= NUM_STEPS'(1);
            r_sc      <= '0;
          end
        end
        S_EXEC: begin
          if (bus.halt) begin
            r_state   <= S_HALTED;
            r_decoded <= '0;
            r_timing  <= '0;
            r_sc      <= '0;
          end else if (bus.sc_clr || w_term) begin
            r_state   <= S_IDLE;
            r_decoded <= '0;
            r_timing  <= '0;
            r_sc      <= '0;
            r_done    <= 1'b1;
          end else begin
            // timing stays one-hot of r_sc by shifting in lockstep with the increment
            r_sc     <= r_sc + SC_WIDTH'(1);
            r_timing <= {r_timing[NUM_STEPS-2:0], 1'b0};
          end
        end
        S_HALTED: begin
          r_state <= S_HALTED;
        end
        default: begin
          r_state   <= S_IDLE;
          r_decoded <= '0;
          r_timing  <= '0;
          r_sc      <= '0;
        end
      endcase
    end
  end

  assign bus.opcode_ready   = w_ready;
  assign bus.decoded_signal = r_decoded;
  assign bus.timing_signal  = r_timing;
  assign bus.sc_count       = r_sc;
  assign bus.busy           = (r_state == S_EXEC);
  assign bus.instr_done     = r_done;
  assign bus.halted         = (r_state == S_HALTED);
endmodule
